// File: rtl/ram_pkg.sv
// Shared types and constants for the ram_bank data store.
package ram_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  // Data width must split into whole byte lanes.
  function automatic bit dw_is_byte_multiple(input int dw);
    return (dw > 0) && ((dw % BYTE_W) == 0);
  endfunction

endpackage

// File: rtl/ram_array.sv
// Byte-lane storage array: synchronous byte-enabled write, combinational read, no reset.
// Zero latency on the read path; no flow control, every enabled write lands on the edge.
module ram_array
  import ram_pkg::*;
#(
  parameter int DW   = 16,
  parameter int AW   = 7,
  parameter int BE_W = DW / 8
) (
  input  logic            clk,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [DW-1:0]   wr_data,
  input  logic [BE_W-1:0] wr_be,
  input  logic [AW-1:0]   rd_addr,
  output logic [DW-1:0]   rd_data
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < BE_W; i++) begin
        if (wr_be[i]) begin
          mem[wr_addr][i*BYTE_W +: BYTE_W] <= wr_data[i*BYTE_W +: BYTE_W];
        end
      end
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/ram_bank.sv
// Single-clock data RAM with zero-fill after reset, write-first bypass and range checking.
// Read latency 1, or 2 when built with RAM_BANK_OUTREG_EN; requests are ignored until ready.
module ram_bank
  import ram_pkg::*;
#(
  parameter int DW     = 16,
  parameter int AW     = 13,
  parameter int RAM_AW = 7,
  parameter int BE_W   = DW / 8
) (
  input  logic            clk,
  input  logic            rst,
  output logic            ready,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [DW-1:0]   wr_data,
  input  logic [BE_W-1:0] wr_be,
  input  logic            rd_en,
  input  logic [AW-1:0]   rd_addr,
  output logic [DW-1:0]   rd_data,
  output logic            rd_valid,
  output logic            addr_err
);

  if (!dw_is_byte_multiple(DW)) begin : g_dw_check
    $error("ram_bank: DW must be a non-zero multiple of 8");
  end
  if (RAM_AW > AW) begin : g_aw_check
    $error("ram_bank: RAM_AW must not exceed AW");
  end

  state_t            state;
  state_t            state_nxt;
  logic [RAM_AW-1:0] cnt;
  logic [RAM_AW-1:0] cnt_nxt;
  logic              clr_we;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ST_CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    clr_we    = 1'b0;
    case (state)
      ST_CLEAR: begin
        clr_we  = 1'b1;
        cnt_nxt = cnt + 1'b1;
        if (cnt == {RAM_AW{1'b1}}) begin
          state_nxt = ST_RUN;
        end
      end
      ST_RUN:  state_nxt = ST_RUN;
      default: state_nxt = ST_CLEAR;
    endcase
  end

  assign ready = (state == ST_RUN);

  logic wr_oor;
  logic rd_oor;

  if (RAM_AW < AW) begin : g_range
    assign wr_oor = |wr_addr[AW-1:RAM_AW];
    assign rd_oor = |rd_addr[AW-1:RAM_AW];
  end else begin : g_full_range
    assign wr_oor = 1'b0;
    assign rd_oor = 1'b0;
  end

  // Nothing is accepted on a reset edge, even if the FSM is still in RUN.
  logic run;
  logic wr_acc;
  logic rd_acc;
  logic wr_do;

  assign run    = ready & rst;
  assign wr_acc = run & wr_en;
  assign rd_acc = run & rd_en;
  assign wr_do  = wr_acc & ~wr_oor;

  logic              arr_we;
  logic [RAM_AW-1:0] arr_waddr;
  logic [DW-1:0]     arr_wdata;
  logic [BE_W-1:0]   arr_be;
  logic [DW-1:0]     arr_rdata;

  assign arr_we    = clr_we | wr_do;
  assign arr_waddr = clr_we ? cnt : wr_addr[RAM_AW-1:0];
  assign arr_wdata = clr_we ? '0 : wr_data;
  assign arr_be    = clr_we ? '1 : wr_be;

  ram_array #(
    .DW   (DW),
    .AW   (RAM_AW),
    .BE_W (BE_W)
  ) u_array (
    .clk     (clk),
    .wr_en   (arr_we),
    .wr_addr (arr_waddr),
    .wr_data (arr_wdata),
    .wr_be   (arr_be),
    .rd_addr (rd_addr[RAM_AW-1:0]),
    .rd_data (arr_rdata)
  );

  // Write-first: enabled lanes of a same-cycle write to the read address win.
  logic          hit;
  logic [DW-1:0] rd_next;

  assign hit = wr_do & (wr_addr[RAM_AW-1:0] == rd_addr[RAM_AW-1:0]);

  always_comb begin
    rd_next = arr_rdata;
    for (int i = 0; i < BE_W; i++) begin
      if (hit && wr_be[i]) begin
        rd_next[i*BYTE_W +: BYTE_W] = wr_data[i*BYTE_W +: BYTE_W];
      end
    end
    if (rd_oor) begin
      rd_next = '0;
    end
  end

  logic [DW-1:0] rd_data_q;
  logic          rd_valid_q;
  logic          addr_err_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_acc;
      addr_err_q <= (wr_acc & wr_oor) | (rd_acc & rd_oor);
      if (rd_acc) begin
        rd_data_q <= rd_next;
      end
    end
  end

`ifdef RAM_BANK_OUTREG_EN
  logic [DW-1:0] rd_data_q2;
  logic          rd_valid_q2;
  logic          addr_err_q2;

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_data_q2  <= '0;
      rd_valid_q2 <= 1'b0;
      addr_err_q2 <= 1'b0;
    end else begin
      rd_data_q2  <= rd_data_q;
      rd_valid_q2 <= rd_valid_q;
      addr_err_q2 <= addr_err_q;
    end
  end

  assign rd_data  = rd_data_q2;
  assign rd_valid = rd_valid_q2;
  assign addr_err = addr_err_q2;
`else
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign addr_err = addr_err_q;
`endif

endmodule

// File: tb/tb_ram_bank.sv
// Testbench for ram_bank: directed vector table plus randomized traffic against a reference model.
module tb_ram_bank;

`ifdef RAM_BANK_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam int DEPTH = 128;

  logic        clk;
  logic        rst;
  logic        ready;
  logic        wr_en;
  logic [12:0] wr_addr;
  logic [15:0] wr_data;
  logic [1:0]  wr_be;
  logic        rd_en;
  logic [12:0] rd_addr;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic        addr_err;

  ram_bank #(.DW(16), .AW(13), .RAM_AW(7)) dut (
    .clk      (clk),
    .rst      (rst),
    .ready    (ready),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_be    (wr_be),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .addr_err (addr_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [15:0] d;
    logic        e;
  } exp_t;

  typedef struct {
    logic        we;
    logic [12:0] wa;
    logic [15:0] wd;
    logic [1:0]  wbe;
    logic        re;
    logic [12:0] ra;
    logic        ev;
    logic [15:0] ed;
    logic        ee;
  } vec_t;

  int          n_chk  = 0;
  int          n_pass = 0;
  logic [15:0] ref_mem [DEPTH];
  logic        ref_ready = 1'b0;
  int          fill = 0;
  logic [15:0] last_d = 16'h0;
  exp_t        exp_q[$];
  vec_t        vt[15];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, expv);
  endtask

  // One clock: drive at negedge, predict, then compare outputs LAT edges later.
  task automatic step(input logic r, input logic we, input logic [12:0] wa, input logic [15:0] wd,
                      input logic [1:0] wbe, input logic re, input logic [12:0] ra);
    exp_t        e;
    logic [15:0] v;
    rst = r; wr_en = we; wr_addr = wa; wr_data = wd; wr_be = wbe; rd_en = re; rd_addr = ra;
    if (!r) begin
      exp_q.delete();
      for (int k = 0; k < LAT; k++) exp_q.push_back('{1'b0, 16'h0, 1'b0});
      last_d = 16'h0; fill = 0; ref_ready = 1'b0;
    end else begin
      e.v = ref_ready && re;
      e.e = ref_ready && ((we && wa >= 13'(DEPTH)) || (re && ra >= 13'(DEPTH)));
      if (ref_ready && re) begin
        if (ra >= 13'(DEPTH)) v = 16'h0;
        else begin
          v = ref_mem[ra[6:0]];
          if (we && wa == ra)
            for (int b = 0; b < 2; b++) if (wbe[b]) v[b*8 +: 8] = wd[b*8 +: 8];
        end
        last_d = v;
      end
      e.d = last_d;
      exp_q.push_back(e);
      if (ref_ready && we && wa < 13'(DEPTH))
        for (int b = 0; b < 2; b++) if (wbe[b]) ref_mem[wa[6:0]][b*8 +: 8] = wd[b*8 +: 8];
    end
    @(posedge clk);
    if (r && !ref_ready) begin
      fill++;
      if (fill == DEPTH) begin
        ref_ready = 1'b1;
        for (int k = 0; k < DEPTH; k++) ref_mem[k] = 16'h0;
      end
    end
    @(negedge clk);
    chk("ready", 32'(ready), 32'(ref_ready));
    if (exp_q.size() >= LAT) begin
      e = exp_q.pop_front();
      chk("rd_valid", 32'(rd_valid), 32'(e.v));
      chk("rd_data", 32'(rd_data), 32'(e.d));
      chk("addr_err", 32'(addr_err), 32'(e.e));
    end
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 13'h0, 16'h0, 2'b00, 1'b0, 13'h0);
  endtask

  function automatic logic [12:0] pick();
    int r;
    r = int'($urandom_range(0, 9));
    if (r < 7) return 13'($urandom_range(0, 7));
    else if (r < 9) return 13'(128 + $urandom_range(0, 3));
    else return 13'($urandom);
  endfunction

  task automatic rand_step();
    step(1'b1, 1'($urandom), pick(), 16'($urandom), 2'($urandom), 1'($urandom), pick());
  endtask

  function automatic vec_t mk(logic we, logic [12:0] wa, logic [15:0] wd, logic [1:0] wbe,
                              logic re, logic [12:0] ra, logic ev, logic [15:0] ed, logic ee);
    vec_t t;
    t.we = we; t.wa = wa; t.wd = wd; t.wbe = wbe; t.re = re; t.ra = ra;
    t.ev = ev; t.ed = ed; t.ee = ee;
    return t;
  endfunction

  initial begin
    int n;
    clk = 1'b0; rst = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0;
    rd_en = 1'b0; rd_addr = '0;

    vt[0]  = mk(1'b0, 13'h000, 16'h0000, 2'b00, 1'b1, 13'h000, 1'b1, 16'h0000, 1'b0);
    vt[1]  = mk(1'b0, 13'h000, 16'h0000, 2'b00, 1'b1, 13'h040, 1'b1, 16'h0000, 1'b0);
    vt[2]  = mk(1'b0, 13'h000, 16'h0000, 2'b00, 1'b1, 13'h07F, 1'b1, 16'h0000, 1'b0);
    vt[3]  = mk(1'b1, 13'h005, 16'hA5C3, 2'b11, 1'b0, 13'h000, 1'b0, 16'h0000, 1'b0);
    vt[4]  = mk(1'b1, 13'h005, 16'h11FF, 2'b01, 1'b0, 13'h000, 1'b0, 16'h0000, 1'b0);
    vt[5]  = mk(1'b0, 13'h000, 16'h0000, 2'b00, 1'b1, 13'h005, 1'b1, 16'hA5FF, 1'b0);
    vt[6]  = mk(1'b1, 13'h009, 16'h1234, 2'b11, 1'b0, 13'h000, 1'b0, 16'hA5FF, 1'b0);
    vt[7]  = mk(1'b1, 13'h009, 16'hABCD, 2'b10, 1'b1, 13'h009, 1'b1, 16'hAB34, 1'b0);
    vt[8]  = mk(1'b0, 13'h000, 16'h0000, 2'b00, 1'b1, 13'h009, 1'b1, 16'hAB34, 1'b0);
    vt[9]  = mk(1'b1, 13'h085, 16'hBEEF, 2'b11, 1'b0, 13'h000, 1'b0, 16'hAB34, 1'b1);
    vt[10] = mk(1'b0, 13'h000, 16'h0000, 2'b00, 1'b1, 13'h085, 1'b1, 16'h0000, 1'b1);
    vt[11] = mk(1'b0, 13'h000, 16'h0000, 2'b00, 1'b1, 13'h005, 1'b1, 16'hA5FF, 1'b0);
    vt[12] = mk(1'b1, 13'h085, 16'hBEEF, 2'b11, 1'b1, 13'h1005, 1'b1, 16'h0000, 1'b1);
    vt[13] = mk(1'b1, 13'h005, 16'hBEEF, 2'b00, 1'b1, 13'h005, 1'b1, 16'hA5FF, 1'b0);
    vt[14] = mk(1'b1, 13'h085, 16'hBEEF, 2'b11, 1'b1, 13'h005, 1'b1, 16'hA5FF, 1'b1);

    @(negedge clk);
    repeat (3) step(1'b0, 1'b0, 13'h0, 16'h0, 2'b00, 1'b0, 13'h0);
    n = 0;
    while (!ready && n < 300) begin
      idle();
      n++;
    end
    chk("fill_cycles", 32'(n), 32'd128);

    foreach (vt[i]) begin
      step(1'b1, vt[i].we, vt[i].wa, vt[i].wd, vt[i].wbe, vt[i].re, vt[i].ra);
      for (int k = 1; k < LAT; k++) idle();
      chk($sformatf("vec%0d_valid", i), 32'(rd_valid), 32'(vt[i].ev));
      chk($sformatf("vec%0d_data", i), 32'(rd_data), 32'(vt[i].ed));
      chk($sformatf("vec%0d_err", i), 32'(addr_err), 32'(vt[i].ee));
    end

    repeat (400) rand_step();

    // Reset from RUN, then again 50 cycles into the fill, with traffic throughout.
    step(1'b0, 1'b1, 13'h3, 16'h5555, 2'b11, 1'b1, 13'h3);
    repeat (50) rand_step();
    step(1'b0, 1'b1, 13'h4, 16'h6666, 2'b11, 1'b1, 13'h85);
    n = 0;
    while (!ready && n < 300) begin
      rand_step();
      n++;
    end
    chk("refill_cycles", 32'(n), 32'd128);
    step(1'b1, 1'b0, 13'h0, 16'h0, 2'b00, 1'b1, 13'h000);
    step(1'b1, 1'b0, 13'h0, 16'h0, 2'b00, 1'b1, 13'h040);
    step(1'b1, 1'b0, 13'h0, 16'h0, 2'b00, 1'b1, 13'h07F);
    repeat (200) rand_step();
    for (int k = 0; k < LAT; k++) idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
